// File: rtl/multiply_map_engine.sv
// multiply_map_engine: sequential u32[origin+i] *= u32[modifier+i] executor with snapshot-safe ordering.
// Build macro MULTIPLY_MAP_SAT_EN saturates products to all-ones instead of truncating them.
module multiply_map_engine #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int NUM_FLAGS = 4,
  parameter int SEL_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_origin,
  input  logic [ADDR_W-1:0]    cmd_modifier,
  input  logic [ADDR_W:0]      cmd_length,
  input  logic [SEL_W-1:0]     cmd_cond_sel,
  input  logic [NUM_FLAGS-1:0] flags,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_a_addr,
  output logic [ADDR_W-1:0]    rd_b_addr,
  input  logic [DATA_W-1:0]    rd_a_data,
  input  logic [DATA_W-1:0]    rd_b_data,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 skipped
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_r;
  state_t              next_state_s;
  logic                accept_s;
  logic                skip_s;
  logic [ADDR_W:0]     cnt_r;
  logic [ADDR_W:0]     len_r;
  logic                desc_r;
  logic                rd_en_r;
  logic [ADDR_W-1:0]   rd_a_addr_r;
  logic [ADDR_W-1:0]   rd_b_addr_r;
  logic                data_vld_r;
  logic [ADDR_W-1:0]   a_addr_d1_r;
  logic                wr_en_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [DATA_W-1:0]   wr_data_r;
  logic                cmd_ready_r;
  logic                busy_r;
  logic                done_r;
  logic                skipped_r;

  function automatic logic cond_eval(input logic [SEL_W-1:0] sel, input logic [NUM_FLAGS-1:0] f);
    logic result;
    result = (sel == {SEL_W{1'b0}});
    for (int k = 0; k < NUM_FLAGS; k++) begin
      result = result | ((int'(sel) == (k + 1)) & f[k]);
    end
    return result;
  endfunction

  function automatic logic [DATA_W-1:0] mul_word(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef MULTIPLY_MAP_SAT_EN
    logic [2*DATA_W-1:0] full;
    full = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    if (full[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}}) begin
      return {DATA_W{1'b1}};
    end else begin
      return full[DATA_W-1:0];
    end
`else
    return a * b;
`endif
  endfunction

  assign accept_s = cmd_valid && (state_r == IDLE);
  assign skip_s   = !cond_eval(cmd_cond_sel, flags) || (cmd_length == {(ADDR_W+1){1'b0}});

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = skip_s ? FIN : RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == len_r) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = RUN;
        end
      end
      // The last product is in flight while data_vld_r is high.
      DRAIN: begin
        if (!data_vld_r) begin
          next_state_s = FIN;
        end else begin
          next_state_s = DRAIN;
        end
      end
      FIN:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Read issue, operand pipeline, product register and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      skipped_r   <= 1'b0;
      cnt_r       <= {(ADDR_W+1){1'b0}};
      len_r       <= {(ADDR_W+1){1'b0}};
      desc_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_a_addr_r <= {ADDR_W{1'b0}};
      rd_b_addr_r <= {ADDR_W{1'b0}};
      data_vld_r  <= 1'b0;
      a_addr_d1_r <= {ADDR_W{1'b0}};
      wr_en_r     <= 1'b0;
      wr_addr_r   <= {ADDR_W{1'b0}};
      wr_data_r   <= {DATA_W{1'b0}};
    end else begin
      cmd_ready_r <= (next_state_s == IDLE);
      busy_r      <= (next_state_s != IDLE);
      done_r      <= (next_state_s == FIN);
      skipped_r   <= (next_state_s == FIN) && (state_r == IDLE);
      data_vld_r  <= rd_en_r;
      a_addr_d1_r <= rd_a_addr_r;
      wr_en_r     <= data_vld_r;
      if (data_vld_r) begin
        wr_addr_r <= a_addr_d1_r;
        wr_data_r <= mul_word(rd_a_data, rd_b_data);
      end
      // Walking downwards when modifier < origin keeps every read ahead of the write that clobbers it.
      if (accept_s && !skip_s) begin
        len_r   <= cmd_length;
        desc_r  <= (cmd_modifier < cmd_origin);
        cnt_r   <= CNT_ONE;
        rd_en_r <= 1'b1;
        if (cmd_modifier < cmd_origin) begin
          rd_a_addr_r <= cmd_origin + cmd_length[ADDR_W-1:0] - ADDR_ONE;
          rd_b_addr_r <= cmd_modifier + cmd_length[ADDR_W-1:0] - ADDR_ONE;
        end else begin
          rd_a_addr_r <= cmd_origin;
          rd_b_addr_r <= cmd_modifier;
        end
      end else if ((state_r == RUN) && (cnt_r != len_r)) begin
        cnt_r   <= cnt_r + CNT_ONE;
        rd_en_r <= 1'b1;
        if (desc_r) begin
          rd_a_addr_r <= rd_a_addr_r - ADDR_ONE;
          rd_b_addr_r <= rd_b_addr_r - ADDR_ONE;
        end else begin
          rd_a_addr_r <= rd_a_addr_r + ADDR_ONE;
          rd_b_addr_r <= rd_b_addr_r + ADDR_ONE;
        end
      end else begin
        rd_en_r <= 1'b0;
      end
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign skipped   = skipped_r;
  assign rd_en     = rd_en_r;
  assign rd_a_addr = rd_a_addr_r;
  assign rd_b_addr = rd_b_addr_r;
  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;

endmodule

// File: tb/tb_multiply_map_engine.sv
// Directed self-checking bench for multiply_map_engine with a synchronous-read word memory model.
module tb_multiply_map_engine;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_origin;
  logic [7:0]  cmd_modifier;
  logic [8:0]  cmd_length;
  logic [2:0]  cmd_cond_sel;
  logic [3:0]  flags;
  logic        rd_en;
  logic [7:0]  rd_a_addr;
  logic [7:0]  rd_b_addr;
  logic [31:0] rd_a_data;
  logic [31:0] rd_b_data;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        skipped;

  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  int checks;
  int passes;
  int fails;
  logic [7:0]  exp_addr [$];
  logic [31:0] exp_data [$];

`ifdef MULTIPLY_MAP_SAT_EN
  localparam logic [31:0] EXP_OVF = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_SQ  = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_OVF = 32'hFFFF_FFFE;
  localparam logic [31:0] EXP_SQ  = 32'h0000_0000;
`endif

  multiply_map_engine dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_origin(cmd_origin), .cmd_modifier(cmd_modifier), .cmd_length(cmd_length),
    .cmd_cond_sel(cmd_cond_sel), .flags(flags), .rd_en(rd_en), .rd_a_addr(rd_a_addr),
    .rd_b_addr(rd_b_addr), .rd_a_data(rd_a_data), .rd_b_data(rd_b_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .skipped(skipped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: one-cycle read latency, old data returned on a same-edge write.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) begin
      rd_a_data <= mem[rd_a_addr];
      rd_b_data <= mem[rd_b_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [7:0] o, input logic [7:0] m, input logic [8:0] l, input logic [2:0] s);
    cmd_origin = o; cmd_modifier = m; cmd_length = l; cmd_cond_sel = s; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_origin = 8'hAA; cmd_modifier = 8'h55; cmd_length = 9'd7; cmd_cond_sel = 3'd0;
  endtask

  // Executing command: checks every cycle from accept to the next ready, writes against exp_* queues.
  task automatic run_exec(input logic [7:0] o, input logic [7:0] m, input logic [8:0] l,
                          input logic [2:0] s, input logic [3:0] flags_after);
    int n;
    n = int'(l);
    check("ready_before", 64'(cmd_ready), 64'(1'b1));
    issue(o, m, l, s);
    flags = flags_after;
    for (int c = 1; c <= n + 4; c++) begin
      check("rd_en", 64'(rd_en), 64'(c <= n));
      check("wr_en", 64'(wr_en), 64'(c >= 3 && c <= n + 2));
      check("done", 64'(done), 64'(c == n + 3));
      check("skipped", 64'(skipped), 64'(1'b0));
      check("busy", 64'(busy), 64'(c <= n + 3));
      check("cmd_ready", 64'(cmd_ready), 64'(c == n + 4));
      if (c >= 3 && c <= n + 2) begin
        check("wr_addr", 64'(wr_addr), 64'(exp_addr.pop_front()));
        check("wr_data", 64'(wr_data), 64'(exp_data.pop_front()));
      end
      if (c < n + 4) tick();
    end
  endtask

  task automatic run_skip(input logic [7:0] o, input logic [7:0] m, input logic [8:0] l, input logic [2:0] s);
    check("skip_ready_before", 64'(cmd_ready), 64'(1'b1));
    issue(o, m, l, s);
    check("skip_done", 64'(done), 64'(1'b1));
    check("skip_skipped", 64'(skipped), 64'(1'b1));
    check("skip_busy", 64'(busy), 64'(1'b1));
    check("skip_ready", 64'(cmd_ready), 64'(1'b0));
    check("skip_rd_en", 64'(rd_en), 64'(1'b0));
    check("skip_wr_en", 64'(wr_en), 64'(1'b0));
    tick();
    check("skip_done_clear", 64'(done), 64'(1'b0));
    check("skip_ready_back", 64'(cmd_ready), 64'(1'b1));
    check("skip_busy_clear", 64'(busy), 64'(1'b0));
    check("skip_rd_en2", 64'(rd_en), 64'(1'b0));
  endtask

  initial begin
    checks = 0; passes = 0; fails = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_origin = 8'h00; cmd_modifier = 8'h00;
    cmd_length = 9'd0; cmd_cond_sel = 3'd0; flags = 4'b0000;
    pl_en = 1'b0; pl_addr = 8'h00; pl_data = 32'h0;
    tick();
    tick();
    check("rst_ready", 64'(cmd_ready), 64'(1'b1));
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_done", 64'(done), 64'(1'b0));
    check("rst_skipped", 64'(skipped), 64'(1'b0));
    check("rst_rd_en", 64'(rd_en), 64'(1'b0));
    check("rst_wr_en", 64'(wr_en), 64'(1'b0));
    check("rst_addrs", 64'({rd_a_addr, rd_b_addr, wr_addr}), 64'(24'h0));
    check("rst_wr_data", 64'(wr_data), 64'(32'h0));
    rst = 1'b0;

    // Basic ascending run.
    poke(8'h10, 32'd2); poke(8'h11, 32'd3); poke(8'h12, 32'd4);
    poke(8'h20, 32'd5); poke(8'h21, 32'd6); poke(8'h22, 32'd7);
    exp_addr = '{8'h10, 8'h11, 8'h12};
    exp_data = '{32'd10, 32'd18, 32'd28};
    run_exec(8'h10, 8'h20, 9'd3, 3'd0, 4'b0000);
    check("mem_10", 64'(mem[8'h10]), 64'(32'd10));
    check("mem_12", 64'(mem[8'h12]), 64'(32'd28));
    check("mem_20", 64'(mem[8'h20]), 64'(32'd5));

    // Overlap with modifier < origin walks downwards.
    poke(8'h04, 32'd1); poke(8'h05, 32'd2); poke(8'h06, 32'd3); poke(8'h07, 32'd4);
    exp_addr = '{8'h07, 8'h06, 8'h05};
    exp_data = '{32'd12, 32'd6, 32'd2};
    run_exec(8'h05, 8'h04, 9'd3, 3'd0, 4'b0000);
    check("ovl_mem4", 64'(mem[8'h04]), 64'(32'd1));
    check("ovl_mem5", 64'(mem[8'h05]), 64'(32'd2));
    check("ovl_mem6", 64'(mem[8'h06]), 64'(32'd6));
    check("ovl_mem7", 64'(mem[8'h07]), 64'(32'd12));

    // Condition false, then true (flags dropped after accept), zero length, out-of-range select.
    poke(8'h30, 32'd3); poke(8'h31, 32'd5); poke(8'h32, 32'd7);
    flags = 4'b0000;
    run_skip(8'h30, 8'h31, 9'd2, 3'd2);
    check("cond_false_mem", 64'(mem[8'h30]), 64'(32'd3));
    flags = 4'b0010;
    exp_addr = '{8'h30, 8'h31};
    exp_data = '{32'd15, 32'd35};
    run_exec(8'h30, 8'h31, 9'd2, 3'd2, 4'b0000);
    check("cond_true_mem30", 64'(mem[8'h30]), 64'(32'd15));
    run_skip(8'h10, 8'h20, 9'd0, 3'd0);
    flags = 4'b1111;
    run_skip(8'h10, 8'h20, 9'd3, 3'd5);
    check("sel5_mem10", 64'(mem[8'h10]), 64'(32'd10));
    flags = 4'b0000;

    // Address wrap plus 32-bit overflow; descending since modifier < origin.
    poke(8'hFE, 32'hFFFF_FFFF); poke(8'hFF, 32'd3); poke(8'h00, 32'd2);
    poke(8'h01, 32'd4); poke(8'h02, 32'd5); poke(8'h03, 32'd6);
    exp_addr = '{8'h01, 8'h00, 8'hFF, 8'hFE};
    exp_data = '{32'd24, 32'd10, 32'd12, EXP_OVF};
    run_exec(8'hFE, 8'h00, 9'd4, 3'd0, 4'b0000);
    check("wrap_memFE", 64'(mem[8'hFE]), 64'(EXP_OVF));
    check("wrap_mem00", 64'(mem[8'h00]), 64'(32'd10));

    // Same base for both operands squares each word.
    poke(8'h40, 32'd7); poke(8'h41, 32'h0001_0000);
    exp_addr = '{8'h40, 8'h41};
    exp_data = '{32'd49, EXP_SQ};
    run_exec(8'h40, 8'h40, 9'd2, 3'd0, 4'b0000);

    // Reset in cycle 2 of an 8-element command.
    poke(8'h50, 32'd9); poke(8'h60, 32'd9);
    issue(8'h50, 8'h60, 9'd8, 3'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_ready", 64'(cmd_ready), 64'(1'b1));
    check("mrst_busy", 64'(busy), 64'(1'b0));
    check("mrst_rd_en", 64'(rd_en), 64'(1'b0));
    check("mrst_wr_en", 64'(wr_en), 64'(1'b0));
    for (int c = 0; c < 10; c++) begin
      tick();
      check("mrst_no_wr", 64'(wr_en), 64'(1'b0));
      check("mrst_no_done", 64'(done), 64'(1'b0));
    end
    check("mrst_mem50", 64'(mem[8'h50]), 64'(32'd9));

    // Back-to-back with cmd_valid held: B accepted exactly when ready returns.
    poke(8'h70, 32'd9); poke(8'h71, 32'd11);
    cmd_origin = 8'h70; cmd_modifier = 8'h71; cmd_length = 9'd1; cmd_cond_sel = 3'd0;
    cmd_valid = 1'b1;
    tick();
    cmd_origin = 8'h71; cmd_modifier = 8'h71; cmd_length = 9'd1;
    for (int c = 1; c <= 4; c++) begin
      check("b2b_ready_low", 64'(cmd_ready), 64'(1'b0));
      check("b2b_rd_en", 64'(rd_en), 64'(c == 1));
      check("b2b_done", 64'(done), 64'(c == 4));
      tick();
    end
    check("b2b_ready_back", 64'(cmd_ready), 64'(1'b1));
    tick();
    cmd_valid = 1'b0;
    check("b2b_second_rd", 64'(rd_en), 64'(1'b1));
    check("b2b_second_addr", 64'(rd_a_addr), 64'(8'h71));
    check("b2b_second_busy", 64'(busy), 64'(1'b1));
    tick();
    tick();
    check("b2b_second_wr_en", 64'(wr_en), 64'(1'b1));
    check("b2b_second_wr_data", 64'(wr_data), 64'(32'd121));
    tick();
    check("b2b_second_done", 64'(done), 64'(1'b1));
    tick();
    check("b2b_mem70", 64'(mem[8'h70]), 64'(32'd99));
    check("b2b_mem71", 64'(mem[8'h71]), 64'(32'd121));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multiply_map_engine.md
Name: multiply_map_engine

Overview:
- Sequential executor for the multiply-map operation: accepts one packed argument command (origin, modifier, length, conditional-flag select) over a valid/ready handshake.
- Performs u32[origin+i] = u32[origin+i] * u32[modifier+i] for i in 0..length-1 against the execution-environment word memory.
- Produces results identical to the snapshot (read-all-then-write) function semantics.
- Sits between the instruction issue stage and the exe_env u32 memory; one element per cycle.

Parameters:
- ADDR_W, 8, width of u32 word address; memory depth 2**ADDR_W.
- DATA_W, 32, word width.
- NUM_FLAGS, 4, number of condition flags visible to the engine.
- SEL_W, 3, width of condition select; must satisfy 2**SEL_W > NUM_FLAGS.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_origin  in  ADDR_W  destination/first-operand base.
- cmd_modifier  in  ADDR_W  second-operand base.
- cmd_length  in  ADDR_W+1  element count, 0..2**ADDR_W.
- cmd_cond_sel  in  SEL_W  0 = always execute; k in 1..NUM_FLAGS = execute iff flags[k-1].
- flags  in  NUM_FLAGS  state condition flags.
- rd_en  out  1  memory read strobe.
- rd_a_addr  out  ADDR_W  operand A address.
- rd_b_addr  out  ADDR_W  operand B address.
- rd_a_data  in  DATA_W  A data, valid 1 cycle after rd_en.
- rd_b_data  in  DATA_W  B data, valid 1 cycle after rd_en.
- wr_en  out  1  memory write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  product.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- skipped  out  1  qualifies done; high when the command performed no writes.

Behaviour:
- Reset values:
  - cmd_ready=1; busy, done, skipped, rd_en, wr_en = 0.
  - All addresses and wr_data = 0.
  - FSM = IDLE.
- cmd_ready = (state==IDLE). Accept on a clk edge where cmd_valid && cmd_ready; capture all cmd_* fields. Sample flags on that same edge.
- Condition:
  - cond true when sel==0, or when 1<=sel<=NUM_FLAGS and flags[sel-1]==1.
  - sel > NUM_FLAGS evaluates false.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE -> FIN on accept when cond false or length==0. FIN drives done=1 and skipped=1 for one cycle, then -> IDLE.
  - IDLE -> RUN on accept otherwise. RUN drives rd_en=1 for exactly length consecutive cycles, then -> DRAIN.
  - DRAIN waits until the last write has issued.
  - Completion: done=1, skipped=0 in the cycle after the final wr_en, then -> IDLE.
- busy = (state != IDLE).
- Pipeline:
  - read issued cycle t; data sampled t+1; product registered.
  - wr_en/wr_addr/wr_data valid cycle t+2.
  - rd_a_addr and wr_addr of the same element are equal.
  - No stalls.
- Ordering (hazard rule):
  - modifier >= origin: ascending, i = 0..L-1.
  - modifier < origin: descending, i = L-1..0.
  - This guarantees every read observes the pre-command value; no forwarding required.
- Addresses wrap modulo 2**ADDR_W (origin+i, modifier+i). length = 2**ADDR_W touches every word exactly once.
- Arithmetic: unsigned DATA_W x DATA_W; wr_data = low DATA_W bits of the product.
- Same address for A and B (origin==modifier) yields the square.
- Latency for L>0: accept at edge 0; rd_en cycles 1..L; wr_en cycles 3..L+2; done cycle L+3. Next accept possible cycle L+4.
- Latency for skipped commands: done at cycle 1; next accept at cycle 2.
- flags changes after accept have no effect. cmd_* changes while busy are ignored.
- rst mid-operation:
  - all outputs return to reset values on the next edge.
  - pending writes are dropped and no done is issued.
  - memory keeps whatever writes already completed.

Optional Feature:
- MULTIPLY_MAP_SAT_EN defined: product saturates; wr_data = all-ones when the full product exceeds 2**DATA_W-1.
- Not defined: truncation to low DATA_W bits. Latency is identical in both builds.

Test Plan:
- origin=0x10, modifier=0x20, L=3, sel=0, mem[0x10..12]={2,3,4}, mem[0x20..22]={5,6,7} -> writes {10,18,28} at cycles 3,4,5 ascending; done at cycle 6, skipped=0.
- Overlap: origin=0x05, modifier=0x04, L=3, mem[4..7]={1,2,3,4} -> descending order; mem[5..7]={2,6,12} (snapshot semantics).
- sel=2 with flags=4'b0000 -> no rd_en/wr_en; done and skipped high at cycle 1. Same with sel=2, flags=4'b0010 -> executes normally. L=0 with sel=0 -> skipped.
- Wrap: origin=0xFE, modifier=0x00, L=4 -> write addresses 0xFE,0xFF,0x00,0x01. Overflow: A=0xFFFF_FFFF, B=2 -> 0xFFFF_FFFE without the macro, 0xFFFF_FFFF with it.
- Assert rst at cycle 2 of an L=8 command -> no wr_en after the reset edge; done never pulses; cmd_ready=1 next cycle.
- Back-to-back: cmd_valid held high with two commands -> second accepted exactly when cmd_ready returns. No accept while busy.
